deserializador_fifo: RTL and testbench

Parametrised successor to the 8-bit serial-to-parallel deserializer. Collects DATA_WIDTH serial bits, qualified one per cycle by write_in, into a word. Completed words go into a DEPTH-entry output FIFO, so the serial producer need not wait for the consumer's ack_in on every word. Bit order is selectable at elaboration; sits between the serial link front end and the parallel consumer in the 100 kHz domain.

---
 rtl/deserializador_fifo.sv | 90 +++++++++
 tb/tb_deserializador_fifo.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/deserializador_fifo.sv
// Serial-to-parallel deserializer with a show-ahead output FIFO.
// Serial bits build a DATA_WIDTH word that is pushed into a DEPTH-entry FIFO for the parallel consumer.
module deserializador_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int MSB_FIRST  = 1
) (
  input  logic                         clk_100KHz,
  input  logic                         reset,
  input  logic                         data_in,
  input  logic                         write_in,
  input  logic                         ack_in,
  output logic                         status_out,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         data_ready,
  output logic [$clog2(DEPTH+1)-1:0]   word_count
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam int PW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH+1);

  logic [CW-1:0]         r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [NW-1:0]         r_count;

  logic                  w_accept;
  logic                  w_last;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_shift_next;

  // Handshake: a serial bit transfers when write_in (valid) and status_out (ready) are both
  // high at a rising edge; a word pops when data_ready (valid) and ack_in (ready) are both high.
  assign status_out = (r_count != NW'(DEPTH));
  assign data_ready = (r_count != '0);
  assign word_count = r_count;
  assign data_out   = data_ready ? r_mem[r_rd_ptr] : '0;

  assign w_accept = write_in & status_out;
  assign w_last   = (r_bit_cnt == CW'(DATA_WIDTH-1));
  assign w_push   = w_accept & w_last;
  assign w_pop    = ack_in & data_ready;

  always_comb begin
    w_shift_next = r_shift;
    if (MSB_FIRST != 0) w_shift_next = {r_shift[DATA_WIDTH-2:0], data_in};
    else                w_shift_next = {data_in, r_shift[DATA_WIDTH-1:1]};
  end

  always_ff @(posedge clk_100KHz) begin
    if (reset) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_bit_cnt <= '0;
        r_shift   <= '0;
      end else begin
        r_bit_cnt <= r_bit_cnt + CW'(1);
        r_shift   <= w_shift_next;
      end
    end
  end

  // Storage needs no reset: data_out is masked until an entry has been written.
  always_ff @(posedge clk_100KHz) begin
    if (w_push) r_mem[r_wr_ptr] <= w_shift_next;
  end

  always_ff @(posedge clk_100KHz) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + NW'(1);
        2'b01:   r_count <= r_count - NW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_deserializador_fifo.sv
// Bench for deserializador_fifo: three configurations share one input stream,
// a vector table covers the basic word path and directed sequences cover FIFO corners.
module tb_deserializador_fifo;

  logic clk = 1'b0;
  logic reset, data_in, write_in, ack_in;

  logic       m_status, m_ready;
  logic [7:0] m_data;
  logic [2:0] m_count;
  logic       l_status, l_ready;
  logic [7:0] l_data;
  logic [2:0] l_count;
  logic        w_status, w_ready;
  logic [11:0] w_data;
  logic [1:0]  w_count;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  deserializador_fifo #(.DATA_WIDTH(8), .DEPTH(4), .MSB_FIRST(1)) u_msb (
    .clk_100KHz(clk), .reset(reset), .data_in(data_in), .write_in(write_in), .ack_in(ack_in),
    .status_out(m_status), .data_out(m_data), .data_ready(m_ready), .word_count(m_count));

  deserializador_fifo #(.DATA_WIDTH(8), .DEPTH(4), .MSB_FIRST(0)) u_lsb (
    .clk_100KHz(clk), .reset(reset), .data_in(data_in), .write_in(write_in), .ack_in(ack_in),
    .status_out(l_status), .data_out(l_data), .data_ready(l_ready), .word_count(l_count));

  deserializador_fifo #(.DATA_WIDTH(12), .DEPTH(2), .MSB_FIRST(1)) u_w12 (
    .clk_100KHz(clk), .reset(reset), .data_in(data_in), .write_in(write_in), .ack_in(ack_in),
    .status_out(w_status), .data_out(w_data), .data_ready(w_ready), .word_count(w_count));

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; data_in = 1'b0; write_in = 1'b0; ack_in = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // driver: shifts w bits of v out MSB first, write_in held high throughout
  task automatic send_bits(input logic [15:0] v, input int w);
    for (int i = w - 1; i >= 0; i--) begin
      data_in  = v[i];
      write_in = 1'b1;
      step();
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic       d, w, a;
    logic       exp_ready;
    logic [7:0] exp_data;
    logic [2:0] exp_cnt;
    logic       exp_status;
    logic [7:0] exp_lsb;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 8'h00};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 8'h00};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 8'h00};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 8'h00};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 8'h00};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 8'h00};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hAD, 3'd1, 1'b1, 8'hB5};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 8'h00};

    do_reset();
    check("rst_status", m_status, 1);
    check("rst_ready",  m_ready, 0);
    check("rst_data",   m_data, 0);
    check("rst_count",  m_count, 0);
    check("rst_w12_status", w_status, 1);

    // basic word path, both bit orders
    for (int i = 0; i < 9; i++) begin
      data_in = vecs[i].d; write_in = vecs[i].w; ack_in = vecs[i].a;
      step();
      check($sformatf("vec%0d_ready", i),  m_ready,  vecs[i].exp_ready);
      check($sformatf("vec%0d_data", i),   m_data,   vecs[i].exp_data);
      check($sformatf("vec%0d_count", i),  m_count,  vecs[i].exp_cnt);
      check($sformatf("vec%0d_status", i), m_status, vecs[i].exp_status);
      check($sformatf("vec%0d_lsb", i),    l_data,   vecs[i].exp_lsb);
    end
    ack_in = 1'b0;

    // fill to full, dropped bits while full, ordered drain
    do_reset();
    send_bits(16'h11, 8); exp_q.push_back(8'h11);
    send_bits(16'h22, 8); exp_q.push_back(8'h22);
    send_bits(16'h33, 8); exp_q.push_back(8'h33);
    send_bits(16'h44, 8); exp_q.push_back(8'h44);
    write_in = 1'b0;
    check("full_count",  m_count, 4);
    check("full_status", m_status, 0);
    send_bits(16'hFF, 8);
    write_in = 1'b0;
    check("drop_count", m_count, 4);
    check("drop_head",  m_data, 8'h11);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d_data", i), m_data, exp_q.pop_front());
      ack_in = 1'b1;
      step();
      if (i == 0) check("status_after_pop", m_status, 1);
    end
    ack_in = 1'b0;
    check("drained_ready",  m_ready, 0);
    check("drained_status", m_status, 1);
    check("drained_data",   m_data, 0);

    // simultaneous push and pop with two words held
    do_reset();
    send_bits(16'h66, 8);
    send_bits(16'h77, 8);
    send_bits(16'h2D, 7);
    data_in = 1'b0; write_in = 1'b1; ack_in = 1'b1;
    step();
    write_in = 1'b0; ack_in = 1'b0;
    check("pushpop_count", m_count, 2);
    check("pushpop_head",  m_data, 8'h77);
    ack_in = 1'b1;
    step();
    check("pushpop_next", m_data, 8'h5A);
    step();
    ack_in = 1'b0;
    check("pushpop_empty", m_ready, 0);

    // reset mid-word, then ack on empty
    do_reset();
    send_bits(16'h5, 3);
    write_in = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_count", m_count, 0);
    send_bits(16'hC3, 8);
    write_in = 1'b0;
    check("midrst_data",  m_data, 8'hC3);
    check("midrst_count1", m_count, 1);
    ack_in = 1'b1;
    step();
    check("pop_count", m_count, 0);
    step();
    ack_in = 1'b0;
    check("empty_ack_count", m_count, 0);
    check("empty_ack_ready", m_ready, 0);

    // 12-bit words back to back into a 2-deep FIFO
    do_reset();
    send_bits(16'hABC, 12);
    send_bits(16'h123, 12);
    write_in = 1'b0;
    check("w12_count",  w_count, 2);
    check("w12_status", w_status, 0);
    check("w12_head",   w_data, 12'hABC);
    ack_in = 1'b1;
    step();
    ack_in = 1'b0;
    check("w12_next",   w_data, 12'h123);
    check("w12_count1", w_count, 1);
    check("w12_status1", w_status, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
